idli_sqi_ctrl_m: RTL and testbench
==================================

// Module: idli_sqi_ctrl_m
// PURPOSE
//  Parametrised SQI memory controller; successor to the fixed read-only SQI streamer.
//  - Drives LANES serial SRAMs in lock-step (quad mode), one nibble per lane per beat.
//  - Runs full transactions: command, address, optional dummy, burst data.
//  - Adds a request handshake, a burst length and write support.
//  - Sits between the fetch/ex units and the off-chip memory pins.
// PARAMETERS
//  LANES    2      number of striped SQI devices; data beat width = 4*LANES
//  ADDR_W   24     address bits; must be a multiple of 4; sent MSB nibble first
//  LEN_W    8      burst length field width; beats = len+1
//  DUMMY    2      read dummy beats between address and data
//  CMD_RD   8'h03  read command byte
//  CMD_WR   8'h02  write command byte
// PORTS
//  i_sqc_gck        in   1         clock
//  i_sqc_rst        in   1         synchronous, active-high reset
//  i_sqc_req_vld    in   1         request valid
//  o_sqc_req_rdy    out  1         request accepted when vld&rdy
//  i_sqc_req_wr     in   1         1=write, 0=read
//  i_sqc_req_addr   in   ADDR_W    start address, same on every lane
//  i_sqc_req_len    in   LEN_W     beats minus one
//  o_sqc_rd_data    out  4*LANES   read beat; lane n on bits [4n+3:4n]
//  o_sqc_rd_vld     out  1         one-cycle pulse per read beat; no backpressure
//  i_sqc_wr_data    in   4*LANES   write beat
//  i_sqc_wr_vld     in   1         write beat valid
//  o_sqc_wr_rdy     out  1         write beat consumed when vld&rdy
//  o_sqc_busy       out  1         transaction in progress (state!=IDLE)
//  o_sqc_sck        out  LANES     serial clocks, all lanes identical
//  o_sqc_cs         out  LANES     chip selects, active low
//  i_sqc_sio        in   LANES x 4 data from devices
//  o_sqc_sio        out  LANES x 4 data to devices
//  o_sqc_sio_oe     out  LANES     1=controller drives sio
// BEHAVIOUR
//  - Reset values:
//    - cs=all 1, sck=0, sio=0, oe=0.
//    - rd_vld=0, wr_rdy=0, busy=0; req_rdy=0 during reset, 1 the cycle after.
//  - Reset mid-transaction: next edge forces IDLE and the reset values; no partial beat is emitted.
//  - Beat = 2 gck cycles.
//    - Phase A: sck=0; sio updated.
//    - Phase B: sck=1; device samples / controller samples i_sqc_sio at end of B.
//  - FSM: IDLE -> CMD(2 beats) -> ADDR(ADDR_W/4 beats) -> [DUMMY(DUMMY beats), read only]
//    -> DATA(len+1 beats) -> GAP(2 cycles, cs=1) -> IDLE.
//  - IDLE: req_rdy=1. Accept latches wr/addr/len; cs goes low the next cycle, with CMD beat 0 phase A.
//  - CMD/ADDR: oe=1, command high nibble first, then address MSB nibble first.
//  - DUMMY: oe=0, sck keeps toggling.
//  - DATA read: oe=0; o_sqc_rd_data registered from i_sqc_sio at end of phase B.
//    - rd_vld=1 for exactly the following cycle.
//  - DATA write: oe=1; wr_rdy=1 only in phase A of a data beat.
//    - If wr_vld=0 in phase A, the beat stalls: sck held 0, cs held low, phase A repeats until vld.
//  - Beat counter is LEN_W+1 bits wide; len=all-ones gives 2^LEN_W beats with no wrap.
//  - Device address wrap is the device's concern; the controller never recomputes the address.
//  - req_vld is ignored while busy; GAP guarantees >=2 cycles cs high between transactions.
//  - Back-to-back: a request presented during GAP is accepted on the IDLE cycle that follows.
// CONFIGURATION
//  IDLI_SQI_CTRL_WRITE_EN
//  - Defined: behaviour as above.
//  - Undefined:
//    - i_sqc_req_wr is ignored; every request is a read.
//    - wr_rdy tied 0; write-data datapath and stall logic removed.
// TESTING
//  - Reset: assert rst 3 cycles mid-ADDR -> cs=all 1, sck=0, oe=0, busy=0 next cycle; req_rdy=1 after release.
//  - Read: LANES=2, addr=24'h000010, len=3, model returns 8'hA5,8'h3C,8'hFF,8'h00.
//    - sio shows 0,3 then 0,0,0,0,1,0 (oe=1); 2 dummy beats.
//    - Exactly 4 rd_vld pulses with those values; cs low for (2+6+2+4)*2=28 cycles.
//  - Write with stall: addr=24'h000100, len=1, wr_vld dropped for 5 cycles before beat 1.
//    - sck held 0 and cs low for the 5 cycles; device model holds both beats in order.
//  - Max length: len=8'hFF read -> exactly 256 rd_vld pulses, then GAP, busy=0.
//  - Back-to-back: req_vld held high with 2 reads -> second accepted 2 cycles after cs rises.
//    - No req accepted while busy.
//  - Config: build without IDLI_SQI_CTRL_WRITE_EN, request wr=1 -> CMD nibbles 0,3; read data returned.

Source files
------------

// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: quad-mode SQI memory controller driving LANES striped serial SRAMs in lock-step.
// Write support is compiled in only when IDLI_SQI_CTRL_WRITE_EN is defined; otherwise every request reads.
module idli_sqi_ctrl_m #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned DUMMY  = 2,
    parameter logic [7:0]  CMD_RD = 8'h03,
    parameter logic [7:0]  CMD_WR = 8'h02
) (
    input  logic                 i_sqc_gck,
    input  logic                 i_sqc_rst,
    input  logic                 i_sqc_req_vld,
    output logic                 o_sqc_req_rdy,
    input  logic                 i_sqc_req_wr,
    input  logic [ADDR_W-1:0]    i_sqc_req_addr,
    input  logic [LEN_W-1:0]     i_sqc_req_len,
    output logic [4*LANES-1:0]   o_sqc_rd_data,
    output logic                 o_sqc_rd_vld,
    input  logic [4*LANES-1:0]   i_sqc_wr_data,
    input  logic                 i_sqc_wr_vld,
    output logic                 o_sqc_wr_rdy,
    output logic                 o_sqc_busy,
    output logic [LANES-1:0]     o_sqc_sck,
    output logic [LANES-1:0]     o_sqc_cs,
    input  logic [4*LANES-1:0]   i_sqc_sio,
    output logic [4*LANES-1:0]   o_sqc_sio,
    output logic [LANES-1:0]     o_sqc_sio_oe
);

    localparam int unsigned DW      = 4 * LANES;
    localparam int unsigned ANIB    = ADDR_W / 4;
    localparam int unsigned ANIB_CW = $clog2(ANIB + 1);
    localparam int unsigned DUM_CW  = $clog2(DUMMY + 1);
    localparam int unsigned CNT_A   = ((LEN_W + 1) > ANIB_CW) ? (LEN_W + 1) : ANIB_CW;
    localparam int unsigned CNT_W   = (CNT_A > DUM_CW) ? CNT_A : DUM_CW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_DATA  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_phase;
    logic [CNT_W-1:0]    r_beat;
    logic                r_wr;
    logic [LEN_W-1:0]    r_len;
    logic [ADDR_W-1:0]   r_addr_sh;
    logic [DW-1:0]       r_sio;
    logic [DW-1:0]       r_rd_data;
    logic                r_rd_vld;
    logic                r_req_rdy;
    logic                r_busy;
    logic                r_wr_rdy;
    logic [LANES-1:0]    r_cs;
    logic [LANES-1:0]    r_sck;
    logic [LANES-1:0]    r_oe;

    state_t              w_nxt_state;
    logic                w_nxt_phase;
    logic [CNT_W-1:0]    w_nxt_beat;
    logic                w_nxt_wr;
    logic [LEN_W-1:0]    w_nxt_len;
    logic [ADDR_W-1:0]   w_nxt_addr_sh;
    logic [DW-1:0]       w_nxt_sio;
    logic [DW-1:0]       w_nxt_rd_data;
    logic                w_nxt_rd_vld;
    logic                w_nxt_active;
    logic                w_nxt_drive;
    logic                w_nxt_wr_rdy;
    logic                w_req_wr;
    logic [7:0]          w_req_cmd;
    logic [7:0]          w_cmd;

`ifdef IDLI_SQI_CTRL_WRITE_EN
    assign w_req_wr     = i_sqc_req_wr;
    assign w_nxt_wr_rdy = (w_nxt_state == S_DATA) && w_nxt_wr && !w_nxt_phase;
`else
    // Write inputs have no function in a read-only build.
    logic w_unused_wr;
    assign w_unused_wr  = ^{i_sqc_req_wr, i_sqc_wr_data, i_sqc_wr_vld};
    assign w_req_wr     = 1'b0;
    assign w_nxt_wr_rdy = 1'b0;
`endif

    assign w_req_cmd = w_req_wr ? CMD_WR : CMD_RD;
    assign w_cmd     = r_wr ? CMD_WR : CMD_RD;

    assign w_nxt_active = (w_nxt_state == S_CMD)   || (w_nxt_state == S_ADDR) ||
                          (w_nxt_state == S_DUMMY) || (w_nxt_state == S_DATA);
    assign w_nxt_drive  = (w_nxt_state == S_CMD) || (w_nxt_state == S_ADDR) ||
                          ((w_nxt_state == S_DATA) && w_nxt_wr);

    // Next-state logic: each beat is phase A (sck low, sio launched) then phase B (sck high).
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_phase   = r_phase;
        w_nxt_beat    = r_beat;
        w_nxt_wr      = r_wr;
        w_nxt_len     = r_len;
        w_nxt_addr_sh = r_addr_sh;
        w_nxt_sio     = r_sio;
        w_nxt_rd_data = r_rd_data;
        w_nxt_rd_vld  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_sqc_req_vld && r_req_rdy) begin
                    w_nxt_state   = S_CMD;
                    w_nxt_phase   = 1'b0;
                    w_nxt_beat    = '0;
                    w_nxt_wr      = w_req_wr;
                    w_nxt_len     = i_sqc_req_len;
                    w_nxt_addr_sh = i_sqc_req_addr;
                    w_nxt_sio     = {LANES{w_req_cmd[7:4]}};
                end
            end
            S_CMD: begin
                if (!r_phase) begin
                    w_nxt_phase = 1'b1;
                end else begin
                    w_nxt_phase = 1'b0;
                    if (r_beat == CNT_W'(1)) begin
                        w_nxt_state   = S_ADDR;
                        w_nxt_beat    = '0;
                        w_nxt_sio     = {LANES{r_addr_sh[ADDR_W-1 -: 4]}};
                        w_nxt_addr_sh = r_addr_sh << 4;
                    end else begin
                        w_nxt_beat = r_beat + CNT_W'(1);
                        w_nxt_sio  = {LANES{w_cmd[3:0]}};
                    end
                end
            end
            S_ADDR: begin
                if (!r_phase) begin
                    w_nxt_phase = 1'b1;
                end else begin
                    w_nxt_phase = 1'b0;
                    if (r_beat == CNT_W'(ANIB - 1)) begin
                        w_nxt_beat = '0;
                        if (r_wr) begin
                            w_nxt_state = S_DATA;
                        end else if (DUMMY != 0) begin
                            w_nxt_state = S_DUMMY;
                            w_nxt_sio   = '0;
                        end else begin
                            w_nxt_state = S_DATA;
                            w_nxt_sio   = '0;
                        end
                    end else begin
                        w_nxt_beat    = r_beat + CNT_W'(1);
                        w_nxt_sio     = {LANES{r_addr_sh[ADDR_W-1 -: 4]}};
                        w_nxt_addr_sh = r_addr_sh << 4;
                    end
                end
            end
            S_DUMMY: begin
                if (!r_phase) begin
                    w_nxt_phase = 1'b1;
                end else begin
                    w_nxt_phase = 1'b0;
                    if (r_beat == CNT_W'(DUMMY - 1)) begin
                        w_nxt_state = S_DATA;
                        w_nxt_beat  = '0;
                    end else begin
                        w_nxt_beat = r_beat + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (!r_phase) begin
`ifdef IDLI_SQI_CTRL_WRITE_EN
                    // Write beats hold in phase A with sck low until a beat is offered.
                    if (!r_wr) begin
                        w_nxt_phase = 1'b1;
                    end else if (i_sqc_wr_vld && r_wr_rdy) begin
                        w_nxt_sio   = i_sqc_wr_data;
                        w_nxt_phase = 1'b1;
                    end
`else
                    w_nxt_phase = 1'b1;
`endif
                end else begin
                    if (!r_wr) begin
                        w_nxt_rd_data = i_sqc_sio;
                        w_nxt_rd_vld  = 1'b1;
                    end
                    w_nxt_phase = 1'b0;
                    if (r_beat == CNT_W'(r_len)) begin
                        w_nxt_state = S_GAP;
                        w_nxt_beat  = '0;
                        w_nxt_sio   = '0;
                    end else begin
                        w_nxt_beat = r_beat + CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (!r_phase) begin
                    w_nxt_phase = 1'b1;
                end else begin
                    w_nxt_phase = 1'b0;
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_phase = 1'b0;
                w_nxt_beat  = '0;
            end
        endcase
    end

    // State and registered pin/handshake outputs.
    always_ff @(posedge i_sqc_gck) begin
        if (i_sqc_rst) begin
            r_state   <= S_IDLE;
            r_phase   <= 1'b0;
            r_beat    <= '0;
            r_wr      <= 1'b0;
            r_len     <= '0;
            r_addr_sh <= '0;
            r_sio     <= '0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_req_rdy <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_rdy  <= 1'b0;
            r_cs      <= '1;
            r_sck     <= '0;
            r_oe      <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_phase   <= w_nxt_phase;
            r_beat    <= w_nxt_beat;
            r_wr      <= w_nxt_wr;
            r_len     <= w_nxt_len;
            r_addr_sh <= w_nxt_addr_sh;
            r_sio     <= w_nxt_sio;
            r_rd_data <= w_nxt_rd_data;
            r_rd_vld  <= w_nxt_rd_vld;
            r_req_rdy <= (w_nxt_state == S_IDLE);
            r_busy    <= (w_nxt_state != S_IDLE);
            r_wr_rdy  <= w_nxt_wr_rdy;
            r_cs      <= w_nxt_active ? '0 : '1;
            r_sck     <= {LANES{w_nxt_active & w_nxt_phase}};
            r_oe      <= {LANES{w_nxt_drive}};
        end
    end

    assign o_sqc_req_rdy = r_req_rdy;
    assign o_sqc_rd_data = r_rd_data;
    assign o_sqc_rd_vld  = r_rd_vld;
    assign o_sqc_wr_rdy  = r_wr_rdy;
    assign o_sqc_busy    = r_busy;
    assign o_sqc_sck     = r_sck;
    assign o_sqc_cs      = r_cs;
    assign o_sqc_sio     = r_sio;
    assign o_sqc_sio_oe  = r_oe;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m with a behavioural striped SQI device on the pins.
`timescale 1ns/1ps
module tb_idli_sqi_ctrl_m;

    localparam int unsigned LANES  = 2;
    localparam int unsigned DW     = 4 * LANES;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_sqc_req_vld = 1'b0;
    logic              i_sqc_req_wr = 1'b0;
    logic [ADDR_W-1:0] i_sqc_req_addr = '0;
    logic [LEN_W-1:0]  i_sqc_req_len = '0;
    logic [DW-1:0]     i_sqc_wr_data = '0;
    logic              i_sqc_wr_vld = 1'b0;
    logic [DW-1:0]     i_sqc_sio = '0;
    logic              o_sqc_req_rdy;
    logic [DW-1:0]     o_sqc_rd_data;
    logic              o_sqc_rd_vld;
    logic              o_sqc_wr_rdy;
    logic              o_sqc_busy;
    logic [LANES-1:0]  o_sqc_sck;
    logic [LANES-1:0]  o_sqc_cs;
    logic [DW-1:0]     o_sqc_sio;
    logic [LANES-1:0]  o_sqc_sio_oe;

    int checks = 0;
    int failures = 0;

    idli_sqi_ctrl_m dut (
        .i_sqc_gck      (clk),
        .i_sqc_rst      (rst),
        .i_sqc_req_vld  (i_sqc_req_vld),
        .o_sqc_req_rdy  (o_sqc_req_rdy),
        .i_sqc_req_wr   (i_sqc_req_wr),
        .i_sqc_req_addr (i_sqc_req_addr),
        .i_sqc_req_len  (i_sqc_req_len),
        .o_sqc_rd_data  (o_sqc_rd_data),
        .o_sqc_rd_vld   (o_sqc_rd_vld),
        .i_sqc_wr_data  (i_sqc_wr_data),
        .i_sqc_wr_vld   (i_sqc_wr_vld),
        .o_sqc_wr_rdy   (o_sqc_wr_rdy),
        .o_sqc_busy     (o_sqc_busy),
        .o_sqc_sck      (o_sqc_sck),
        .o_sqc_cs       (o_sqc_cs),
        .i_sqc_sio      (i_sqc_sio),
        .o_sqc_sio      (o_sqc_sio),
        .o_sqc_sio_oe   (o_sqc_sio_oe)
    );

    always #5 clk = ~clk;

    // Device model: logs driven nibbles on sck-high cycles and presents read data in phase A.
    logic [DW-1:0] dev_rd [0:511];
    logic [DW-1:0] dev_log [$];
    int dev_cnt = 0;
    int dev_hdr = 10;

    always @(negedge clk) begin
        if (o_sqc_cs[0]) begin
            dev_cnt = 0;
        end else if (o_sqc_sck[0]) begin
            if (o_sqc_sio_oe[0]) dev_log.push_back(o_sqc_sio);
            dev_cnt = dev_cnt + 1;
        end else if (dev_cnt >= dev_hdr && (dev_cnt - dev_hdr) < 512) begin
            i_sqc_sio = dev_rd[dev_cnt - dev_hdr];
        end else begin
            i_sqc_sio = '0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int            m_cs_low;
    int            m_gap_hi;
    int            m_rdy_busy;
    int            m_wr_rdy_seen;
    bit            m_timeout;
    logic [DW-1:0] m_rd_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(output bit ok);
        ok = 1'b0;
        i_sqc_req_vld = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (o_sqc_req_rdy) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic monitor(input int budget);
        m_cs_low = 0; m_gap_hi = 0; m_rdy_busy = 0; m_wr_rdy_seen = 0;
        m_timeout = 1'b1;
        m_rd_q.delete();
        for (int c = 0; c < budget; c++) begin
            if (!o_sqc_busy) begin
                m_timeout = 1'b0;
                break;
            end
            if (o_sqc_cs != '1) m_cs_low++; else m_gap_hi++;
            if (o_sqc_req_rdy) m_rdy_busy++;
            if (o_sqc_wr_rdy) m_wr_rdy_seen++;
            if (o_sqc_rd_vld) m_rd_q.push_back(o_sqc_rd_data);
            step();
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        repeat (2) step();
        checks++; if (o_sqc_cs !== 2'b11) begin failures++; $display("FAIL rst_cs got=%b exp=11", o_sqc_cs); end
        checks++; if (o_sqc_sck !== 2'b00) begin failures++; $display("FAIL rst_sck got=%b exp=00", o_sqc_sck); end
        checks++; if (o_sqc_sio_oe !== 2'b00 || o_sqc_sio !== 8'h00) begin failures++; $display("FAIL rst_sio got oe=%b sio=%h exp 00/00", o_sqc_sio_oe, o_sqc_sio); end
        checks++; if ({o_sqc_busy, o_sqc_rd_vld, o_sqc_wr_rdy, o_sqc_req_rdy} !== 4'b0000) begin failures++; $display("FAIL rst_ctl got busy/rdv/wrr/rqr=%b exp=0000", {o_sqc_busy, o_sqc_rd_vld, o_sqc_wr_rdy, o_sqc_req_rdy}); end
        rst = 1'b0;
        step();
        checks++; if (o_sqc_req_rdy !== 1'b1) begin failures++; $display("FAIL rst_release_rdy got=%b exp=1", o_sqc_req_rdy); end

        // Reset in the middle of the address phase.
        dev_hdr = 10;
        i_sqc_req_wr = 1'b0; i_sqc_req_addr = 24'h123456; i_sqc_req_len = 8'd0;
        do_accept(ok);
        i_sqc_req_vld = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL rst_accept got=timeout exp=accept"); end
        repeat (6) step();
        checks++; if (o_sqc_sio !== 8'h22 || o_sqc_cs !== 2'b00) begin failures++; $display("FAIL rst_mid_addr got sio=%h cs=%b exp 22/00", o_sqc_sio, o_sqc_cs); end
        rst = 1'b1;
        step();
        checks++; if (o_sqc_cs !== 2'b11 || o_sqc_sck !== 2'b00 || o_sqc_sio_oe !== 2'b00) begin failures++; $display("FAIL rst_mid_pins got cs=%b sck=%b oe=%b exp 11/00/00", o_sqc_cs, o_sqc_sck, o_sqc_sio_oe); end
        checks++; if (o_sqc_busy !== 1'b0 || o_sqc_rd_vld !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl got busy=%b rdv=%b exp 0/0", o_sqc_busy, o_sqc_rd_vld); end
        repeat (2) step();
        checks++; if (o_sqc_req_rdy !== 1'b0) begin failures++; $display("FAIL rst_hold_rdy got=%b exp=0", o_sqc_req_rdy); end
        rst = 1'b0;
        step();
        checks++; if (o_sqc_req_rdy !== 1'b1 || o_sqc_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_release got rdy=%b busy=%b exp 1/0", o_sqc_req_rdy, o_sqc_busy); end
    endtask

    task automatic test_read();
        bit ok;
        logic [DW-1:0] exp_rd [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        logic [DW-1:0] exp_log [8] = '{8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00};
        for (int i = 0; i < 4; i++) dev_rd[i] = exp_rd[i];
        dev_hdr = 10;
        dev_log.delete();
        i_sqc_req_wr = 1'b0; i_sqc_req_addr = 24'h000010; i_sqc_req_len = 8'd3;
        do_accept(ok);
        i_sqc_req_vld = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL rd_accept got=timeout exp=accept"); end
        checks++; if (o_sqc_cs !== 2'b00 || o_sqc_sio_oe !== 2'b11 || o_sqc_busy !== 1'b1) begin failures++; $display("FAIL rd_first_beat got cs=%b oe=%b busy=%b exp 00/11/1", o_sqc_cs, o_sqc_sio_oe, o_sqc_busy); end
        monitor(200);
        checks++; if (m_timeout) begin failures++; $display("FAIL rd_done got=timeout exp=idle"); end
        checks++; if (m_cs_low != 28) begin failures++; $display("FAIL rd_cs_low got=%0d exp=28", m_cs_low); end
        checks++; if (m_gap_hi != 2) begin failures++; $display("FAIL rd_gap got=%0d exp=2", m_gap_hi); end
        checks++; if (m_rdy_busy != 0) begin failures++; $display("FAIL rd_rdy_busy got=%0d exp=0", m_rdy_busy); end
        checks++; if (m_rd_q.size() != 4) begin failures++; $display("FAIL rd_pulses got=%0d exp=4", m_rd_q.size()); end
        for (int i = 0; i < 4 && i < m_rd_q.size(); i++) begin
            checks++; if (m_rd_q[i] !== exp_rd[i]) begin failures++; $display("FAIL rd_data[%0d] got=%h exp=%h", i, m_rd_q[i], exp_rd[i]); end
        end
        checks++; if (dev_log.size() != 8) begin failures++; $display("FAIL rd_log_len got=%0d exp=8", dev_log.size()); end
        for (int i = 0; i < 8 && i < dev_log.size(); i++) begin
            checks++; if (dev_log[i] !== exp_log[i]) begin failures++; $display("FAIL rd_sio[%0d] got=%h exp=%h", i, dev_log[i], exp_log[i]); end
        end
    endtask

    task automatic test_max_len();
        bit ok;
        int bad;
        for (int i = 0; i < 256; i++) dev_rd[i] = DW'(i * 37 + 5);
        dev_hdr = 10;
        i_sqc_req_wr = 1'b0; i_sqc_req_addr = 24'hFFFFF0; i_sqc_req_len = 8'hFF;
        do_accept(ok);
        i_sqc_req_vld = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL max_accept got=timeout exp=accept"); end
        monitor(800);
        checks++; if (m_timeout) begin failures++; $display("FAIL max_done got=timeout exp=idle"); end
        checks++; if (m_rd_q.size() != 256) begin failures++; $display("FAIL max_pulses got=%0d exp=256", m_rd_q.size()); end
        bad = 0;
        for (int i = 0; i < m_rd_q.size() && i < 256; i++) if (m_rd_q[i] !== DW'(i * 37 + 5)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL max_data got=%0d bad beats exp=0", bad); end
        checks++; if (m_cs_low != 532 || m_gap_hi != 2) begin failures++; $display("FAIL max_timing got cs_low=%0d gap=%0d exp 532/2", m_cs_low, m_gap_hi); end
        checks++; if (o_sqc_busy !== 1'b0 || o_sqc_req_rdy !== 1'b1) begin failures++; $display("FAIL max_idle got busy=%b rdy=%b exp 0/1", o_sqc_busy, o_sqc_req_rdy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int rise, acc, rd1, busy_rdy;
        logic cs_prev;
        dev_rd[0] = 8'h6E; dev_rd[1] = 8'h91;
        dev_hdr = 10;
        i_sqc_req_wr = 1'b0; i_sqc_req_addr = 24'h000200; i_sqc_req_len = 8'd0;
        do_accept(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_accept1 got=timeout exp=accept"); end
        i_sqc_req_addr = 24'h000300; i_sqc_req_len = 8'd1;
        rise = -1; acc = -1; rd1 = 0; busy_rdy = 0; cs_prev = o_sqc_cs[0];
        for (int c = 0; c < 100; c++) begin
            if (o_sqc_busy && o_sqc_req_rdy) busy_rdy++;
            if (o_sqc_rd_vld) begin
                rd1++;
                checks++; if (o_sqc_rd_data !== 8'h6E) begin failures++; $display("FAIL b2b_data1 got=%h exp=6e", o_sqc_rd_data); end
            end
            if (rise < 0 && !cs_prev && o_sqc_cs[0]) rise = c;
            cs_prev = o_sqc_cs[0];
            if (o_sqc_req_rdy) begin
                acc = c;
                step();
                break;
            end
            step();
        end
        i_sqc_req_vld = 1'b0;
        checks++; if (acc < 0 || rise < 0 || acc - rise != 2) begin failures++; $display("FAIL b2b_gap got rise=%0d accept=%0d exp accept=rise+2", rise, acc); end
        checks++; if (busy_rdy != 0 || rd1 != 1) begin failures++; $display("FAIL b2b_first got rdy_busy=%0d pulses=%0d exp 0/1", busy_rdy, rd1); end
        monitor(200);
        checks++; if (m_timeout || m_rd_q.size() != 2) begin failures++; $display("FAIL b2b_second got timeout=%0d pulses=%0d exp 0/2", m_timeout, m_rd_q.size()); end
        if (m_rd_q.size() == 2) begin
            checks++; if (m_rd_q[0] !== 8'h6E || m_rd_q[1] !== 8'h91) begin failures++; $display("FAIL b2b_data2 got=%h,%h exp=6e,91", m_rd_q[0], m_rd_q[1]); end
        end
        checks++; if (m_cs_low != 24) begin failures++; $display("FAIL b2b_cs_low got=%0d exp=24", m_cs_low); end
    endtask

`ifdef IDLI_SQI_CTRL_WRITE_EN
    task automatic test_write();
        bit ok;
        int consumed, stall, viol, cs_low, done;
        logic [DW-1:0] exp_log [10] = '{8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h5A, 8'hC3};
        dev_hdr = 1000;
        dev_log.delete();
        i_sqc_req_wr = 1'b1; i_sqc_req_addr = 24'h000100; i_sqc_req_len = 8'd1;
        do_accept(ok);
        i_sqc_req_vld = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL wr_accept got=timeout exp=accept"); end
        consumed = 0; stall = 0; viol = 0; cs_low = 0; done = 0;
        for (int c = 0; c < 200; c++) begin
            if (!o_sqc_busy) begin done = 1; break; end
            if (o_sqc_cs != '1) cs_low++;
            if (o_sqc_wr_rdy) begin
                if (consumed == 1 && stall < 5) begin
                    i_sqc_wr_vld = 1'b0;
                    stall++;
                    if (o_sqc_sck !== 2'b00 || o_sqc_cs !== 2'b00) viol++;
                end else begin
                    i_sqc_wr_vld  = 1'b1;
                    i_sqc_wr_data = (consumed == 0) ? 8'h5A : 8'hC3;
                    consumed++;
                end
            end else begin
                i_sqc_wr_vld = 1'b0;
            end
            step();
        end
        i_sqc_wr_vld = 1'b0;
        checks++; if (done != 1 || consumed != 2 || stall != 5) begin failures++; $display("FAIL wr_flow got done=%0d beats=%0d stalls=%0d exp 1/2/5", done, consumed, stall); end
        checks++; if (viol != 0) begin failures++; $display("FAIL wr_stall_pins got=%0d exp=0", viol); end
        checks++; if (cs_low != 25) begin failures++; $display("FAIL wr_cs_low got=%0d exp=25", cs_low); end
        checks++; if (dev_log.size() != 10) begin failures++; $display("FAIL wr_log_len got=%0d exp=10", dev_log.size()); end
        for (int i = 0; i < 10 && i < dev_log.size(); i++) begin
            checks++; if (dev_log[i] !== exp_log[i]) begin failures++; $display("FAIL wr_sio[%0d] got=%h exp=%h", i, dev_log[i], exp_log[i]); end
        end
    endtask
`else
    task automatic test_config();
        bit ok;
        dev_rd[0] = 8'h96;
        dev_hdr = 10;
        dev_log.delete();
        i_sqc_req_wr = 1'b1; i_sqc_req_addr = 24'h000020; i_sqc_req_len = 8'd0;
        i_sqc_wr_vld = 1'b1; i_sqc_wr_data = 8'hEE;
        do_accept(ok);
        i_sqc_req_vld = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL cfg_accept got=timeout exp=accept"); end
        monitor(200);
        i_sqc_wr_vld = 1'b0; i_sqc_req_wr = 1'b0;
        checks++; if (m_timeout || m_cs_low != 22) begin failures++; $display("FAIL cfg_timing got timeout=%0d cs_low=%0d exp 0/22", m_timeout, m_cs_low); end
        checks++; if (dev_log.size() != 8) begin failures++; $display("FAIL cfg_log_len got=%0d exp=8", dev_log.size()); end
        if (dev_log.size() >= 2) begin
            checks++; if (dev_log[0] !== 8'h00 || dev_log[1] !== 8'h33) begin failures++; $display("FAIL cfg_cmd got=%h,%h exp=00,33", dev_log[0], dev_log[1]); end
        end
        checks++; if (m_wr_rdy_seen != 0) begin failures++; $display("FAIL cfg_wr_rdy got=%0d exp=0", m_wr_rdy_seen); end
        checks++; if (m_rd_q.size() != 1) begin failures++; $display("FAIL cfg_pulses got=%0d exp=1", m_rd_q.size()); end
        if (m_rd_q.size() == 1) begin
            checks++; if (m_rd_q[0] !== 8'h96) begin failures++; $display("FAIL cfg_data got=%h exp=96", m_rd_q[0]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_max_len();
        test_back_to_back();
`ifdef IDLI_SQI_CTRL_WRITE_EN
        test_write();
`else
        test_config();
`endif
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
